// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings and the LSU state type.
package rv32i_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {LSU_IDLE, LSU_REQ, LSU_WAIT, LSU_DONE} lsu_state_e;
endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational store lane replication/strobes and load lane extraction/extension.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_strb_o,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [31:0] ld_data_o
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wdata_o = st_data_i;
    st_strb_o  = 4'b1111;
    case (st_f3_i)
      F3_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_strb_o  = 4'b0001 << st_off_i;
      end
      F3_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_strb_o  = st_off_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_word_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_word_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = ld_word_i;
    case (ld_f3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data_o = {24'h000000, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data_o = {16'h0000, ld_half};
      default: ;
    endcase
  end
endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single-outstanding req/gnt/rvalid bus master with
// alignment checks, lane alignment, load extension and a REQ+WAIT timeout.
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  input  logic        lsu_is_store,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        is_store_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  strb_q;
  logic [31:0] wdata_q;

  logic        accept, rdata_upd, illegal, misal, timeout;
  logic [31:0] st_wdata, ld_data;
  logic [3:0]  st_strb;

  lsu_align u_align (
    .st_f3_i    (lsu_funct3),
    .st_off_i   (lsu_addr[1:0]),
    .st_data_i  (lsu_wdata),
    .st_wdata_o (st_wdata),
    .st_strb_o  (st_strb),
    .ld_f3_i    (f3_q),
    .ld_off_i   (off_q),
    .ld_word_i  (mem_rdata),
    .ld_data_o  (ld_data)
  );

  assign illegal = lsu_is_store ? (lsu_funct3 > F3_W)
                                : (lsu_funct3 == 3'b011 || lsu_funct3 == 3'b110 ||
                                   lsu_funct3 == 3'b111);
  assign misal = ((lsu_funct3 == F3_H || lsu_funct3 == F3_HU) && lsu_addr[0]) ||
                 (lsu_funct3 == F3_W && lsu_addr[1:0] != 2'b00);
  // Timeout wins over a same-cycle gnt/rvalid so the op count stays bounded.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    accept    = 1'b0;
    rdata_upd = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (lsu_valid) begin
          cnt_d = '0;
          if (illegal || misal) begin
            state_d = LSU_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = LSU_REQ;
            err_d   = 1'b0;
            accept  = 1'b1;
          end
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
        end else if (mem_gnt) begin
          state_d = is_store_q ? LSU_DONE : LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout) begin
          state_d = LSU_DONE;
          err_d   = 1'b1;
        end else if (mem_rvalid) begin
          state_d   = LSU_DONE;
          rdata_upd = 1'b1;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      rdata_q    <= 32'h0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      strb_q     <= 4'b0000;
      wdata_q    <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        is_store_q <= lsu_is_store;
        f3_q       <= lsu_funct3;
        off_q      <= lsu_addr[1:0];
        we_q       <= lsu_is_store;
        addr_q     <= {lsu_addr[31:2], 2'b00};
        strb_q     <= lsu_is_store ? st_strb : 4'b0000;
        wdata_q    <= lsu_is_store ? st_wdata : 32'h0;
      end
      if (rdata_upd) rdata_q <= ld_data;
    end
  end

  assign lsu_busy  = (state_q != LSU_IDLE);
  assign lsu_done  = (state_q == LSU_DONE);
  assign lsu_err   = (state_q == LSU_DONE) && err_q;
  assign lsu_rdata = rdata_q;
  assign mem_req   = (state_q == LSU_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = strb_q;
  assign mem_wdata = wdata_q;
endmodule
